ofm_writeback: RTL

//  Write-back stage directly downstream of the conv/maxpool datapath in TOP; writes into ofm_dpram.

---
 rtl/ofm_wb_pkg.sv | 25 ++
 rtl/ofm_addr_gen.sv | 49 ++++
 rtl/ofm_writeback.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ofm_wb_pkg.sv
// Shared definitions for the OFM write-back stage: state encoding, widths
// and the active-lane helper.
package ofm_wb_pkg;

  localparam int ADDR_W  = 20;  // $clog2(692224)
  localparam int PLANE_W = 18;  // ofm_size^2 for a 9-bit ofm_size
  localparam int GRP_W   = 7;   // filter-group index
  localparam int NF_W    = 11;  // num_filter width
  localparam int SIZE_W  = 9;   // ofm_size width
  localparam int IADDR_W = 32;  // internal address width, wide enough to detect out-of-range

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Lanes carrying real filters in a group: min(lanes, filters left).
  function automatic logic [NF_W-1:0] min_lanes(input logic [NF_W-1:0] remain,
                                                 input logic [NF_W-1:0] lanes);
    return (remain < lanes) ? remain : lanes;
  endfunction

endpackage

// File: rtl/ofm_addr_gen.sv
// Incremental element-address generator. lane_addr always holds the address
// of the lane currently being written; no multiplier in the update path.
module ofm_addr_gen
  import ofm_wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               next_lane,
  input  logic               next_pixel,
  input  logic               next_group,
  input  logic [PLANE_W-1:0] plane,
  input  logic [IADDR_W-1:0] group_step,
  output logic [IADDR_W-1:0] lane_addr
);

  logic [IADDR_W-1:0] pix_base;
  logic [IADDR_W-1:0] group_base;
  logic [IADDR_W-1:0] group_next;
  logic [IADDR_W-1:0] pix_next;

  assign group_next = group_base + group_step;
  assign pix_next   = pix_base + IADDR_W'(1);

  // Advance bases and the per-lane address; next group wins over next pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      pix_base   <= '0;
      group_base <= '0;
      lane_addr  <= '0;
    end else if (load) begin
      pix_base   <= '0;
      group_base <= '0;
      lane_addr  <= '0;
    end else if (next_group) begin
      group_base <= group_next;
      pix_base   <= group_next;
      lane_addr  <= group_next;
    end else if (next_pixel) begin
      pix_base  <= pix_next;
      lane_addr <= pix_next;
    end else if (next_lane) begin
      lane_addr <= lane_addr + IADDR_W'(plane);
    end
  end

endmodule

// File: rtl/ofm_writeback.sv
// OFM write-back: takes one SYSTOLIC_SIZE-lane pixel vector per beat and
// serialises it into one ofm_dpram element write per active lane, using the
// channel-major address filter*plane + row*ofm_size + col.
// Build option: define OFM_RELU_EN to clamp negative lane values to 0.
module ofm_writeback
  import ofm_wb_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int OFM_RAM_SIZE  = 692224
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [SIZE_W-1:0]                   ofm_size,
  input  logic [NF_W-1:0]                     num_filter,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] in_data,
  output logic                                ofm_wr_en,
  output logic [ADDR_W-1:0]                   ofm_wr_addr,
  output logic [DATA_WIDTH-1:0]               ofm_wr_data,
  output logic                                done
);

  localparam int               BUF_W = SYSTOLIC_SIZE * DATA_WIDTH;
  localparam logic [NF_W-1:0]  LANES = NF_W'(SYSTOLIC_SIZE);

  state_t             state, state_nxt;
  logic [PLANE_W-1:0] plane, plane_in, pix_cnt;
  logic [IADDR_W-1:0] group_step, lane_addr;
  logic [NF_W-1:0]    remain, act, lane;
  logic [GRP_W-1:0]   grp, last_grp;
  logic [BUF_W-1:0]   lane_buf;
  logic               last_lane, last_pix, layer_end, in_range, accept;
  logic               load, next_lane, next_pixel, next_group;

  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] v);
`ifdef OFM_RELU_EN
    return v[DATA_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign plane_in  = {{(PLANE_W-SIZE_W){1'b0}}, ofm_size} * {{(PLANE_W-SIZE_W){1'b0}}, ofm_size};
  assign act       = min_lanes(remain, LANES);
  assign last_lane = (lane == act - NF_W'(1));
  assign last_pix  = (pix_cnt == plane - PLANE_W'(1));
  assign layer_end = last_lane && last_pix && (grp == last_grp);
  assign in_range  = (lane_addr < IADDR_W'(OFM_RAM_SIZE));
  assign accept    = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, address-generator controls and write-port outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    state_nxt   = state;
    in_ready    = 1'b0;
    ofm_wr_en   = 1'b0;
    ofm_wr_addr = '0;
    ofm_wr_data = '0;
    done        = 1'b0;
    load        = 1'b0;
    next_lane   = 1'b0;
    next_pixel  = 1'b0;
    next_group  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = DRAIN;
      end
      DRAIN: begin
        ofm_wr_en   = in_range;
        ofm_wr_addr = lane_addr[ADDR_W-1:0];
        ofm_wr_data = relu(lane_buf[DATA_WIDTH-1:0]);
        if (!last_lane) begin
          next_lane = 1'b1;
        end else if (layer_end) begin
          state_nxt = FIN;
        end else begin
          // Accepting on the last-lane cycle keeps the write port busy.
          in_ready   = 1'b1;
          next_pixel = !last_pix;
          next_group = last_pix;
          state_nxt  = in_valid ? DRAIN : WAIT;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Layer configuration, lane buffer and pixel/group/lane counters.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the lane buffer is reset as well, so a beat in flight is discarded
    // and the write data port reads 0 straight out of reset.
    if (!rst_n) begin
      plane      <= '0;
      group_step <= '0;
      remain     <= '0;
      last_grp   <= '0;
      grp        <= '0;
      pix_cnt    <= '0;
      lane       <= '0;
      lane_buf   <= '0;
    end else begin
      if (load) begin
        plane      <= plane_in;
        group_step <= IADDR_W'(plane_in) * IADDR_W'(SYSTOLIC_SIZE);
        remain     <= num_filter;
        last_grp   <= GRP_W'((num_filter - NF_W'(1)) / LANES);
        grp        <= '0;
        pix_cnt    <= '0;
        lane       <= '0;
      end
      if (accept) begin
        lane_buf <= in_data;
        lane     <= '0;
      end else if (next_lane) begin
        lane_buf <= lane_buf >> DATA_WIDTH;
        lane     <= lane + NF_W'(1);
      end
      if (next_pixel) pix_cnt <= pix_cnt + PLANE_W'(1);
      if (next_group) begin
        pix_cnt <= '0;
        grp     <= grp + GRP_W'(1);
        remain  <= remain - LANES;
      end
    end
  end

  ofm_addr_gen u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .next_lane  (next_lane),
    .next_pixel (next_pixel),
    .next_group (next_group),
    .plane      (plane),
    .group_step (group_step),
    .lane_addr  (lane_addr)
  );

endmodule
